inst_encoder: RTL

Converts structured RV32I operation requests (op class, funct3, register indices, immediate) into 32-bit instruction words. Its output format is exactly what the core's decode stage consumes. Requests arrive and words leave over valid/ready handshakes through a registered output stage. The `LI` pseudo-op expands to one or two words. The block serves boot/self-test instruction generation and as a golden-encoding source for decoder verification.

---
 rtl/inst_encoder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: RV32I operation requests -> 32-bit instruction words, LI expanded to LUI+ADDI, illegal requests -> NOP with out_err.
// One-cycle registered output; in_ready drops while a word is held unconsumed or a LUI waits for its ADDI.
module inst_encoder #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [2:0]      in_funct3,
  input  logic            in_alt,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic            out_last,
  output logic            out_err
);

  localparam logic [3:0] CLS_LUI      = 4'd0;
  localparam logic [3:0] CLS_AUIPC    = 4'd1;
  localparam logic [3:0] CLS_JAL      = 4'd2;
  localparam logic [3:0] CLS_JALR     = 4'd3;
  localparam logic [3:0] CLS_BRANCH   = 4'd4;
  localparam logic [3:0] CLS_LOAD     = 4'd5;
  localparam logic [3:0] CLS_STORE    = 4'd6;
  localparam logic [3:0] CLS_OP_IMM   = 4'd7;
  localparam logic [3:0] CLS_OP       = 4'd8;
  localparam logic [3:0] CLS_SYSTEM   = 4'd9;
  localparam logic [3:0] CLS_MISC_MEM = 4'd10;
  localparam logic [3:0] CLS_LI       = 4'd11;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_HI} state_e;

  function automatic logic [31:0] enc_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm12, rs1, f3, rd, opc};
  endfunction

  // Immediate range tests: upper bits must be a pure sign extension.
  logic        fits_i, fits_b, fits_j, fits_shamt, fits_csr;
  logic [19:0] li_hi;

  assign fits_i     = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_b     = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign fits_j     = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
  assign fits_shamt = ~(|in_imm[31:5]);
  assign fits_csr   = ~(|in_imm[31:12]);
  // (imm + 0x800) >> 12: the +0x800 only carries into bit 12 when imm[11] is set.
  assign li_hi      = in_imm[31:12] + {19'd0, in_imm[11]};

  logic [31:0] enc_word, enc_pend;
  logic        enc_two, enc_bad;

  always_comb begin
    enc_word = NOP;
    enc_pend = NOP;
    enc_two  = 1'b0;
    enc_bad  = 1'b0;
    case (in_op)
      CLS_LUI, CLS_AUIPC: begin
        enc_bad  = |in_imm[11:0];
        enc_word = {in_imm[31:12], in_rd, (in_op == CLS_LUI) ? OPC_LUI : OPC_AUIPC};
      end
      CLS_JAL: begin
        enc_bad  = ~fits_j;
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      end
      CLS_JALR: begin
        enc_bad  = ~fits_i | (in_funct3 != 3'b000);
        enc_word = enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR);
      end
      CLS_BRANCH: begin
        enc_bad  = ~fits_b | (in_funct3[2:1] == 2'b01);
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], OPC_BRANCH};
      end
      CLS_LOAD: begin
        enc_bad  = ~fits_i | (in_funct3 == 3'd3) | (in_funct3 == 3'd6) | (in_funct3 == 3'd7);
        enc_word = enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD);
      end
      CLS_STORE: begin
        enc_bad  = ~fits_i | (in_funct3 > 3'd2);
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
      end
      CLS_OP_IMM: begin
        if (in_funct3[1:0] == 2'b01) begin
          // Shifts carry funct7 in imm[11:5]; only SRAI may set it.
          enc_bad  = ~fits_shamt | (in_alt & (in_funct3 != 3'b101));
          enc_word = enc_i({1'b0, in_alt, 5'd0, in_imm[4:0]}, in_rs1, in_funct3, in_rd, OPC_OP_IMM);
        end else begin
          enc_bad  = ~fits_i | in_alt;
          enc_word = enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OP_IMM);
        end
      end
      CLS_OP: begin
        enc_bad  = in_alt & (in_funct3 != 3'b000) & (in_funct3 != 3'b101);
        enc_word = {1'b0, in_alt, 5'd0, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
      end
      CLS_SYSTEM: begin
        if (in_funct3 == 3'b000)
          enc_bad = ~fits_csr | (in_imm[11:0] > 12'd1);
        else if (in_funct3 == 3'b100)
          enc_bad = 1'b1;
        else
          enc_bad = ~fits_csr;
        enc_word = enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_SYSTEM);
      end
      CLS_MISC_MEM: begin
        enc_bad  = ~fits_i | (in_funct3 != 3'b000);
        enc_word = enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_MISC_MEM);
      end
      CLS_LI: begin
        if (fits_i) begin
          enc_word = enc_i(in_imm[11:0], 5'd0, 3'b000, in_rd, OPC_OP_IMM);
        end else begin
          enc_word = {li_hi, in_rd, OPC_LUI};
          enc_pend = enc_i(in_imm[11:0], in_rd, 3'b000, in_rd, OPC_OP_IMM);
          enc_two  = |in_imm[11:0];
        end
      end
      default: enc_bad = 1'b1;
    endcase
    if (enc_bad) begin
      enc_word = NOP;
      enc_two  = 1'b0;
    end
  end

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d, pend_q, pend_d;
  logic        last_q, last_d, err_q, err_d;
  logic        accept, drain;

  assign in_ready  = reset_n && (state_q != ST_HI) && ((state_q == ST_EMPTY) || out_ready);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign out_inst  = inst_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    last_d  = last_q;
    err_d   = err_q;
    pend_d  = pend_q;
    case (state_q)
      ST_EMPTY, ST_FULL: begin
        if (accept) begin
          state_d = enc_two ? ST_HI : ST_FULL;
          inst_d  = enc_word;
          last_d  = ~enc_two;
          err_d   = enc_bad;
          pend_d  = enc_pend;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_HI: begin
        if (drain) begin
          state_d = ST_FULL;
          inst_d  = pend_q;
          last_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      inst_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      last_q  <= last_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

endmodule
